// File: rtl/sprite_compositor.sv
// sprite_compositor
//   N-channel sprite renderer and per-frame collision detector for a
//   640x480 VGA pixel path. Each channel addresses its own external
//   single-port sprite ROM (1-cycle read latency). Colour-key transparency
//   is applied per channel. Channel 0 has the highest priority. The pixel
//   output lags h_cnt/v_cnt by 2 clocks.
//
// Ports:
//   clk_25Hz   pixel clock
//   rst        asynchronous active-low reset
//   h_cnt      horizontal pixel count
//   v_cnt      vertical pixel count
//   valid      display-active flag from the VGA controller
//   spr_x      packed sprite left edges, channel i at [10i+9:10i]
//   spr_y      packed sprite top edges, channel i at [10i+9:10i]
//   spr_en     per-channel enable
//   rom_addr   packed ROM addresses (combinational), channel i at [ADDR_W*i +: ADDR_W]
//   rom_data   packed ROM outputs, valid one cycle after rom_addr
//   pixel      registered RGB444 output
//   coll_mask  sprites involved in the last collision frame (held)
//   coll_pulse one-cycle strobe when coll_mask loads
module sprite_compositor #(
    parameter int          NUM_SPR   = 3,
    parameter int          SPR_W     = 40,
    parameter int          SPR_H     = 30,
    parameter int          ADDR_W    = 12,
    parameter logic [11:0] KEY_COLOR = 12'h000,
    parameter logic [11:0] BG_COLOR  = 12'hfff,
    parameter int          HOLD_BITS = 20
) (
    input  logic                      clk_25Hz,
    input  logic                      rst,
    input  logic [9:0]                h_cnt,
    input  logic [9:0]                v_cnt,
    input  logic                      valid,
    input  logic [NUM_SPR*10-1:0]     spr_x,
    input  logic [NUM_SPR*10-1:0]     spr_y,
    input  logic [NUM_SPR-1:0]        spr_en,
    output logic [NUM_SPR*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPR*12-1:0]     rom_data,
    output logic [11:0]               pixel,
    output logic [NUM_SPR-1:0]        coll_mask,
    output logic                      coll_pulse
);

    localparam logic [31:0]          SPR_W_U  = 32'(SPR_W);
    localparam logic [31:0]          SPR_H_U  = 32'(SPR_H);
    localparam logic [NUM_SPR-1:0]   SPR_ONE  = {{(NUM_SPR-1){1'b0}}, 1'b1};
    localparam logic [HOLD_BITS-1:0] HOLD_ONE = {{(HOLD_BITS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Stage 0: range test and ROM address (combinational)
    // ------------------------------------------------------------------
    logic [NUM_SPR-1:0] in0;
    logic [9:0]         sx, sy, dx, dy;
    logic [31:0]        lin;

    always_comb begin
        in0      = '0;
        rom_addr = '0;
        sx       = '0;
        sy       = '0;
        dx       = '0;
        dy       = '0;
        lin      = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            sx  = spr_x[10*i +: 10];
            sy  = spr_y[10*i +: 10];
            // Differences are only meaningful once the >= checks hold,
            // so a wrapped subtraction can never produce a false hit.
            dx  = h_cnt - sx;
            dy  = v_cnt - sy;
            lin = '0;
            if (spr_en[i] && (h_cnt >= sx) && (v_cnt >= sy) &&
                (32'(dx) < SPR_W_U) && (32'(dy) < SPR_H_U)) begin
                in0[i] = 1'b1;
                lin    = 32'(dy) * SPR_W_U + 32'(dx);
                rom_addr[ADDR_W*i +: ADDR_W] = lin[ADDR_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: registers aligned with rom_data
    // ------------------------------------------------------------------
    logic [NUM_SPR-1:0] in1_q;
    logic               valid1_q;
    logic               fs1_q;

    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            in1_q    <= '0;
            valid1_q <= 1'b0;
            fs1_q    <= 1'b0;
        end else begin
            in1_q    <= in0;
            valid1_q <= valid;
            fs1_q    <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

    logic [NUM_SPR-1:0] opaque;
    logic               multi;
    logic [NUM_SPR-1:0] coll_term;

    always_comb begin
        opaque = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            opaque[i] = in1_q[i] && (rom_data[12*i +: 12] != KEY_COLOR);
        end
        // Two or more bits set: clearing the lowest set bit leaves a remainder.
        multi     = |(opaque & (opaque - SPR_ONE));
        coll_term = (valid1_q && multi) ? opaque : '0;
    end

    // ------------------------------------------------------------------
    // Stage 2: priority mux into the output pixel register
    // ------------------------------------------------------------------
    logic [11:0] pixel_d, pixel_q;
    logic        found;

    always_comb begin
        pixel_d = BG_COLOR;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (!found && opaque[i]) begin
                pixel_d = rom_data[12*i +: 12];
                found   = 1'b1;
            end
        end
        if (!valid1_q) begin
            pixel_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Collision accumulation, latch and hold timer
    // ------------------------------------------------------------------
    logic [NUM_SPR-1:0]   acc_d, acc_q;
    logic [NUM_SPR-1:0]   mask_d, mask_q;
    logic [HOLD_BITS-1:0] hold_d, hold_q;
    logic                 pulse_d, pulse_q;

    always_comb begin
        acc_d   = acc_q | coll_term;
        mask_d  = mask_q;
        hold_d  = hold_q;
        pulse_d = 1'b0;
        if ((mask_q != '0) && (hold_q != '1)) begin
            hold_d = hold_q + HOLD_ONE;
        end
        if (fs1_q) begin
            // The boundary pixel belongs to the new frame.
            acc_d = coll_term;
            if ((acc_q != '0) && (acc_q != mask_q)) begin
                mask_d  = acc_q;
                hold_d  = '0;
                pulse_d = 1'b1;
            end else if (hold_q == '1) begin
                mask_d = '0;
            end
        end
    end

    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            pixel_q <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
        end
    end

    assign pixel      = pixel_q;
    assign coll_mask  = mask_q;
    assign coll_pulse = pulse_q;

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

    localparam int NUM_SPR = 3;
    localparam int ADDR_W  = 12;

    logic                      clk_25Hz;
    logic                      rst;
    logic [9:0]                h_cnt, v_cnt;
    logic                      valid;
    logic [NUM_SPR*10-1:0]     spr_x, spr_y;
    logic [NUM_SPR-1:0]        spr_en;
    logic [NUM_SPR*ADDR_W-1:0] rom_addr;
    logic [NUM_SPR*12-1:0]     rom_data;
    logic [11:0]               pixel;
    logic [NUM_SPR-1:0]        coll_mask;
    logic                      coll_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    sprite_compositor #(
        .NUM_SPR  (NUM_SPR),
        .SPR_W    (40),
        .SPR_H    (30),
        .ADDR_W   (ADDR_W),
        .KEY_COLOR(12'h000),
        .BG_COLOR (12'hfff),
        .HOLD_BITS(4)
    ) dut (
        .clk_25Hz  (clk_25Hz),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .valid     (valid),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .spr_en    (spr_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pixel     (pixel),
        .coll_mask (coll_mask),
        .coll_pulse(coll_pulse)
    );

    initial clk_25Hz = 1'b0;
    always #5 clk_25Hz = ~clk_25Hz;

    task automatic tick();
        @(posedge clk_25Hz);
        #1;
    endtask

    task automatic set_hv(input int h, input int v);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // park position outside every sprite used below
    task automatic park();
        set_hv(600, 400);
    endtask

    // frame boundary: h=0,v=0 for one cycle, coll outputs settle two edges later
    task automatic boundary();
        set_hv(0, 0);
        tick();
        park();
        tick();
    endtask

    initial begin
        rst      = 1'b0;
        valid    = 1'b1;
        h_cnt    = 10'd600;
        v_cnt    = 10'd400;
        spr_x    = {10'd500, 10'd500, 10'd100};
        spr_y    = {10'd300, 10'd300, 10'd50};
        spr_en   = 3'b001;
        rom_data = {12'hf00, 12'h00f, 12'h0f0};
        tick();
        tick();
        chk("reset_pixel", 32'(pixel), 32'h000);
        chk("reset_mask", 32'(coll_mask), 32'h0);
        chk("reset_pulse", 32'(coll_pulse), 32'h0);
        rst = 1'b1;

        // single sprite 0 at (100,50)
        set_hv(100, 50);
        chk("addr_topleft", 32'(rom_addr[11:0]), 32'd0);
        tick();
        tick();
        chk("pix_topleft", 32'(pixel), 32'h0f0);
        set_hv(139, 79);
        chk("addr_botright", 32'(rom_addr[11:0]), 32'd1199);
        tick();
        tick();
        chk("pix_botright", 32'(pixel), 32'h0f0);
        set_hv(140, 79);
        chk("addr_outside", 32'(rom_addr[11:0]), 32'd0);
        tick();
        tick();
        chk("pix_outside", 32'(pixel), 32'hfff);

        // priority: sprites 0 and 1 both at (200,100)
        spr_x  = {10'd500, 10'd200, 10'd200};
        spr_y  = {10'd300, 10'd100, 10'd100};
        spr_en = 3'b011;
        set_hv(210, 110);
        chk("addr_ch1", 32'(rom_addr[23:12]), 32'd410);
        tick();
        tick();
        chk("pix_prio0", 32'(pixel), 32'h0f0);
        rom_data = {12'hf00, 12'h00f, 12'h000};
        tick();
        tick();
        chk("pix_key0", 32'(pixel), 32'h00f);

        // clear collision history left by the priority test
        park();
        rst = 1'b0;
        #1;
        chk("rst_pixel_a", 32'(pixel), 32'h000);
        rst = 1'b1;

        // opaque overlap of channels 1 and 2 at (300,200)
        rom_data = {12'hf00, 12'h00f, 12'h0f0};
        spr_x    = {10'd300, 10'd300, 10'd500};
        spr_y    = {10'd200, 10'd200, 10'd300};
        spr_en   = 3'b111;
        tick();
        set_hv(310, 210);
        tick();
        park();
        tick();
        boundary();
        chk("coll_load_mask", 32'(coll_mask), 32'b110);
        chk("coll_load_pulse", 32'(coll_pulse), 32'h1);
        tick();
        chk("coll_pulse_1cyc", 32'(coll_pulse), 32'h0);
        // same overlap in the next frame: no re-pulse
        set_hv(310, 210);
        tick();
        park();
        tick();
        boundary();
        chk("same_mask_kept", 32'(coll_mask), 32'b110);
        chk("same_no_pulse", 32'(coll_pulse), 32'h0);

        // hold timer saturates, mask clears only at a boundary
        for (int i = 0; i < 20; i++) tick();
        chk("hold_before_bnd", 32'(coll_mask), 32'b110);
        boundary();
        chk("hold_cleared", 32'(coll_mask), 32'b000);
        chk("hold_clr_pulse", 32'(coll_pulse), 32'h0);

        // transparent overlap is not a collision
        rom_data = {12'hf00, 12'h000, 12'h0f0};
        set_hv(310, 210);
        tick();
        tick();
        chk("pix_transp_ovl", 32'(pixel), 32'hf00);
        park();
        tick();
        boundary();
        chk("transp_no_coll", 32'(coll_mask), 32'b000);

        // disabled channel never collides
        rom_data = {12'hf00, 12'h00f, 12'h0f0};
        spr_en   = 3'b011;
        set_hv(310, 210);
        tick();
        tick();
        chk("pix_ch2_off", 32'(pixel), 32'h00f);
        park();
        tick();
        boundary();
        chk("dis_no_coll", 32'(coll_mask), 32'b000);

        // valid=0 inside overlapping sprites: black and no accumulation
        spr_en = 3'b111;
        valid  = 1'b0;
        set_hv(310, 210);
        tick();
        tick();
        chk("pix_invalid", 32'(pixel), 32'h000);
        valid = 1'b1;
        park();
        tick();
        tick();
        boundary();
        chk("invalid_no_coll", 32'(coll_mask), 32'b000);

        // collision on the boundary pixel counts toward the new frame
        spr_x = {10'd0, 10'd0, 10'd500};
        spr_y = {10'd0, 10'd0, 10'd300};
        boundary();
        chk("bnd_pix_no_load", 32'(coll_mask), 32'b000);
        spr_x = {10'd300, 10'd300, 10'd500};
        spr_y = {10'd200, 10'd200, 10'd300};
        tick();
        boundary();
        chk("bnd_pix_load", 32'(coll_mask), 32'b110);
        chk("bnd_pix_pulse", 32'(coll_pulse), 32'h1);

        // asynchronous reset mid-frame with non-zero outputs
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_pixel", 32'(pixel), 32'h000);
        chk("rst_mid_mask", 32'(coll_mask), 32'b000);
        chk("rst_mid_pulse", 32'(coll_pulse), 32'h0);
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
